// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: FP scoreboard state encoding, multiply latency
// default, the hard-wired integer zero register and small compare helpers.
package pipeline_pkg;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_DONE = 2'd2
    } sb_state_t;

    localparam int         FPMUL_LAT_DEFAULT = 5;
    localparam logic [4:0] REG_ZERO          = 5'd0;
    localparam logic [15:0] STALL_CNT_MAX    = 16'hFFFF;

    // A source operand hits a destination only if the operand is actually read.
    function automatic logic src_hit(
        input logic       used,
        input logic [4:0] src,
        input logic [4:0] dst
    );
        return used & (src == dst);
    endfunction

    // Either of the two ID source operands hits the destination.
    function automatic logic any_src_hit(
        input logic       used1,
        input logic [4:0] src1,
        input logic       used2,
        input logic [4:0] src2,
        input logic [4:0] dst
    );
        return src_hit(used1, src1, dst) | src_hit(used2, src2, dst);
    endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// Tracks the single in-flight FP multiply: IDLE/BUSY/DONE sequencing, the
// latency countdown and the destination register of the outstanding result.
module fpu_scoreboard
    import pipeline_pkg::*;
#(
    parameter int FPMUL_LAT = FPMUL_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic [4:0] issue_rd,
    output logic       fpu_busy,
    output logic       fpu_done,
    output logic [4:0] fpu_rd
);

    // BUSY spans FPMUL_LAT-1 cycles, so the countdown starts two below latency.
    localparam logic [3:0] CNT_LOAD = 4'(FPMUL_LAT - 2);

    sb_state_t  state_r;
    logic [3:0] cnt_r;
    logic [4:0] rd_r;
    logic       busy_r;
    logic       done_r;

    // Scoreboard state machine with registered busy/done strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= SB_IDLE;
            cnt_r   <= 4'd0;
            rd_r    <= REG_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                SB_IDLE: begin
                    if (issue) begin
                        state_r <= SB_BUSY;
                        cnt_r   <= CNT_LOAD;
                        rd_r    <= issue_rd;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= SB_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                SB_BUSY: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= SB_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= SB_BUSY;
                        cnt_r   <= cnt_r - 4'd1;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                SB_DONE: begin
                    if (issue) begin
                        state_r <= SB_BUSY;
                        cnt_r   <= CNT_LOAD;
                        rd_r    <= issue_rd;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= SB_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= SB_IDLE;
                    cnt_r   <= 4'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fpu_busy = busy_r;
    assign fpu_done = done_r;
    assign fpu_rd   = rd_r;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard detection: load-use and FP-multiply RAW/WAW/structural
// stalls, branch flush, and a saturating stall-cycle counter.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int FPMUL_LAT = FPMUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        id_fp_src,
    input  logic [4:0]  id_rd,
    input  logic        id_fp_dest,
    input  logic        id_fpmul,
    input  logic        ex_mem_read,
    input  logic        ex_reg_we,
    input  logic [4:0]  ex_rd,
    input  logic        ex_fp_dest,
    input  logic        branch_taken,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        fpu_busy,
    output logic        fpu_done,
    output logic [4:0]  fpu_rd,
    output logic [15:0] stall_count
);

    logic        load_use_s;
    logic        fp_hazard_s;
    logic        stall_s;
    logic        flush_s;
    logic        issue_s;
    logic [15:0] stall_count_r;

    // Load-use: integer r0 is hard-wired so it never carries a dependency,
    // while FP f0 is an ordinary register.
    always_comb begin
        load_use_s = 1'b0;
        if (id_valid && ex_mem_read && ex_reg_we && (id_fp_src == ex_fp_dest)) begin
            load_use_s = any_src_hit(id_rs1_used, id_rs1, id_rs2_used, id_rs2, ex_rd)
                         & (ex_fp_dest | (ex_rd != REG_ZERO));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // FP multiply hazards only apply while the result is still in flight;
    // in DONE the register file forwards the write to same-cycle readers.
    always_comb begin
        fp_hazard_s = 1'b0;
        if (id_valid && fpu_busy) begin
            fp_hazard_s = id_fpmul
                        | (id_fp_src & any_src_hit(id_rs1_used, id_rs1,
                                                   id_rs2_used, id_rs2, fpu_rd))
                        | (id_fp_dest & (id_rd == fpu_rd));
        end else begin
            fp_hazard_s = 1'b0;
        end
    end

    // Stall, flush and issue decisions, all forced quiet during reset.
    always_comb begin
        stall_s = 1'b0;
        flush_s = 1'b0;
        issue_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
            flush_s = 1'b0;
            issue_s = 1'b0;
        end else begin
            stall_s = load_use_s | fp_hazard_s;
            flush_s = branch_taken & ~stall_s;
            issue_s = id_valid & id_fpmul & ~stall_s;
        end
    end

    fpu_scoreboard #(
        .FPMUL_LAT (FPMUL_LAT)
    ) u_fpu_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue_s),
        .issue_rd (id_rd),
        .fpu_busy (fpu_busy),
        .fpu_done (fpu_done),
        .fpu_rd   (fpu_rd)
    );

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_r <= 16'd0;
        end else if (stall_s && (stall_count_r != STALL_CNT_MAX)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign pc_hold     = stall_s;
    assign ifid_hold   = stall_s;
    assign idex_bubble = stall_s;
    assign ifid_flush  = flush_s;
    assign stall_count = stall_count_r;

endmodule
